// File: rtl/mem_resp_pkg.sv
// Shared types and default constants for the memory request responder.
// The perf counters are enabled by defining MEM_RESP_PERF_EN.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam int STARVE_LIMIT_DEF = 4;
    localparam int CNT_W_DEF        = 32;

endpackage

// File: rtl/mem_starve_ctr.sv
// Saturating up-counter with synchronous clear, used for the starve count
// and, when MEM_RESP_PERF_EN is defined, for the stall performance counters.
module mem_starve_ctr #(
    parameter int           W     = 3,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_limit
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count    = cnt_q;
    assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_req_responder.sv
// Arbitrates the CPU instruction and data ports onto one single-outstanding
// backing-memory port. Stall perf counters exist only with MEM_RESP_PERF_EN.
module mem_req_responder
    import mem_resp_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_read,
    input  logic [31:0]      imem_address,
    output logic [31:0]      imem_rdata,
    output logic             imem_resp,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic [31:0]      dmem_address,
    input  logic [31:0]      dmem_wdata,
    input  logic [3:0]       dmem_mbe,
    output logic [31:0]      dmem_rdata,
    output logic             dmem_resp,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_mbe,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_resp,
    output logic [CNT_W-1:0] perf_istall,
    output logic [CNT_W-1:0] perf_dstall
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    state_e      state_q, state_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_mbe_q, mem_mbe_d;
    logic        imem_resp_q, imem_resp_d;
    logic        dmem_resp_q, dmem_resp_d;
    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;

    logic          dreq;
    gnt_e          arb_gnt;
    logic          starve_inc;
    logic          starve_clr;
    logic          starve_at_limit;
    logic [SW-1:0] starve_cnt;
    logic          addr_lsb_unused;

    assign dreq            = dmem_read | dmem_write;
    assign addr_lsb_unused = ^{imem_address[1:0], dmem_address[1:0]};

    always_comb begin
        state_d       = state_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_mbe_d     = mem_mbe_q;
        imem_rdata_d  = imem_rdata_q;
        dmem_rdata_d  = dmem_rdata_q;
        imem_resp_d   = 1'b0;
        dmem_resp_d   = 1'b0;
        starve_inc    = 1'b0;
        starve_clr    = 1'b0;
        // dmem wins unless imem is already waiting and has been passed over STARVE_LIMIT times
        arb_gnt = (dreq && (!imem_read || !starve_at_limit)) ? GNT_D : GNT_I;

        unique case (state_q)
            IDLE: begin
                if (arb_gnt == GNT_D) begin
                    state_d       = DBUSY;
                    mem_write_d   = dmem_write;
                    mem_read_d    = !dmem_write;
                    mem_address_d = {dmem_address[31:2], 2'b00};
                    mem_wdata_d   = dmem_write ? dmem_wdata : 32'h0;
                    mem_mbe_d     = dmem_write ? dmem_mbe : 4'hF;
                    starve_inc    = imem_read;
                    starve_clr    = !imem_read;
                end else if (imem_read) begin
                    state_d       = IBUSY;
                    mem_read_d    = 1'b1;
                    mem_write_d   = 1'b0;
                    mem_address_d = {imem_address[31:2], 2'b00};
                    mem_wdata_d   = 32'h0;
                    mem_mbe_d     = 4'hF;
                    starve_clr    = 1'b1;
                end
            end
            IBUSY, DBUSY: begin
                if (mem_resp) begin
                    state_d       = RESP;
                    mem_read_d    = 1'b0;
                    mem_write_d   = 1'b0;
                    mem_address_d = 32'h0;
                    mem_wdata_d   = 32'h0;
                    mem_mbe_d     = 4'h0;
                    if (state_q == IBUSY) begin
                        imem_rdata_d = mem_rdata;
                        imem_resp_d  = 1'b1;
                    end else begin
                        dmem_rdata_d = mem_rdata;
                        dmem_resp_d  = 1'b1;
                    end
                end
            end
            // The CPU still holds the just-completed request here, so it is not re-granted.
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_mbe_q     <= 4'h0;
            imem_resp_q   <= 1'b0;
            dmem_resp_q   <= 1'b0;
            imem_rdata_q  <= 32'h0;
            dmem_rdata_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_mbe_q     <= mem_mbe_d;
            imem_resp_q   <= imem_resp_d;
            dmem_resp_q   <= dmem_resp_d;
            imem_rdata_q  <= imem_rdata_d;
            dmem_rdata_q  <= dmem_rdata_d;
        end
    end

    mem_starve_ctr #(
        .W     (SW),
        .LIMIT (SW'(STARVE_LIMIT))
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .count    (starve_cnt),
        .at_limit (starve_at_limit)
    );

`ifdef MEM_RESP_PERF_EN
    logic perf_i_sat_unused;
    logic perf_d_sat_unused;

    mem_starve_ctr #(
        .W     (CNT_W),
        .LIMIT ({CNT_W{1'b1}})
    ) u_perf_istall (
        .clk      (clk),
        .rst_n    (rst),
        .inc      (imem_read && !imem_resp_q),
        .clr      (1'b0),
        .count    (perf_istall),
        .at_limit (perf_i_sat_unused)
    );

    mem_starve_ctr #(
        .W     (CNT_W),
        .LIMIT ({CNT_W{1'b1}})
    ) u_perf_dstall (
        .clk      (clk),
        .rst_n    (rst),
        .inc      (dreq && !dmem_resp_q),
        .clr      (1'b0),
        .count    (perf_dstall),
        .at_limit (perf_d_sat_unused)
    );
`else
    assign perf_istall = '0;
    assign perf_dstall = '0;
`endif

    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_mbe     = mem_mbe_q;
    assign imem_resp   = imem_resp_q;
    assign dmem_resp   = dmem_resp_q;
    assign imem_rdata  = imem_rdata_q;
    assign dmem_rdata  = dmem_rdata_q;

    // Protocol checks on the CPU and backing-memory sides.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(dmem_read && dmem_write))
                else $error("dmem_read and dmem_write both high; write takes priority");
            assert (!(mem_resp && (state_q == IDLE || state_q == RESP)))
                else $error("mem_resp with no backing access outstanding");
            assert (!(imem_resp_q && dmem_resp_q))
                else $error("imem_resp and dmem_resp high together");
        end
    end

endmodule

// File: tb/tb_mem_req_responder.sv
// Directed self-checking bench for mem_req_responder; expected perf counter
// values follow whether MEM_RESP_PERF_EN is defined for the build.
module tb_mem_req_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mbe;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic [31:0] perf_istall;
    logic [31:0] perf_dstall;

`ifdef MEM_RESP_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_responder dut (
        .clk          (clk),
        .rst          (rst),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_mbe     (dmem_mbe),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_mbe      (mem_mbe),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .perf_istall  (perf_istall),
        .perf_dstall  (perf_dstall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
            else begin
                errors++;
                $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_read    = 1'b0;
        imem_address = 32'h0;
        dmem_read    = 1'b0;
        dmem_write   = 1'b0;
        dmem_address = 32'h0;
        dmem_wdata   = 32'h0;
        dmem_mbe     = 4'h0;
        mem_rdata    = 32'h0;
        mem_resp     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Waits (bounded) for a backing access, answers it with one mem_resp pulse,
    // and returns in the following cycle, where the CPU resp is visible.
    task automatic serve(input logic [31:0] rdata, output logic [31:0] addr, output logic is_wr);
        int n = 0;
        while (!(mem_read || mem_write) && n < 20) begin
            tick();
            n++;
        end
        chk("serve_access_seen", {31'b0, mem_read | mem_write}, 32'd1);
        addr      = mem_address;
        is_wr     = mem_write;
        mem_resp  = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
    endtask

    logic [31:0] got_addr;
    logic        got_wr;
    logic        exp_d [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        clear_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_imem_resp", {31'b0, imem_resp}, 32'd0);
        chk("rst_dmem_resp", {31'b0, dmem_resp}, 32'd0);
        chk("rst_imem_rdata", imem_rdata, 32'h0);
        chk("rst_dmem_rdata", dmem_rdata, 32'h0);
        chk("rst_perf_istall", perf_istall, 32'h0);
        chk("rst_starve", 32'(dut.starve_cnt), 32'h0);
        tick();
        rst = 1'b1;

        // Single fetch: mem_resp three cycles after mem_read rises.
        do_reset();
        imem_read    = 1'b1;
        imem_address = 32'h0000_0040;
        chk("t1_c0_idle", {31'b0, mem_read}, 32'd0);
        tick();
        chk("t1_c1_mem_read", {31'b0, mem_read}, 32'd1);
        chk("t1_c1_addr", mem_address, 32'h0000_0040);
        chk("t1_c1_mbe", {28'b0, mem_mbe}, 32'hF);
        chk("t1_c1_mem_write", {31'b0, mem_write}, 32'd0);
        tick();
        chk("t1_c2_mem_read", {31'b0, mem_read}, 32'd1);
        tick();
        chk("t1_c3_mem_read", {31'b0, mem_read}, 32'd1);
        tick();
        chk("t1_c4_mem_read", {31'b0, mem_read}, 32'd1);
        chk("t1_c4_no_resp_yet", {31'b0, imem_resp}, 32'd0);
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_0013;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        chk("t1_c5_imem_resp", {31'b0, imem_resp}, 32'd1);
        chk("t1_c5_imem_rdata", imem_rdata, 32'h0000_0013);
        chk("t1_c5_mem_read", {31'b0, mem_read}, 32'd0);
        chk("t1_c5_dmem_resp", {31'b0, dmem_resp}, 32'd0);
        tick();
        imem_address = 32'h0000_0044;
        chk("t1_c6_resp_pulse", {31'b0, imem_resp}, 32'd0);
        chk("t1_c6_dead_cycle", {31'b0, mem_read}, 32'd0);
        chk("t1_c6_rdata_hold", imem_rdata, 32'h0000_0013);
        tick();
        chk("t1_c7_next_grant", {31'b0, mem_read}, 32'd1);
        chk("t1_c7_next_addr", mem_address, 32'h0000_0044);
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_00A5;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        imem_read = 1'b0;
        chk("t1_c8_imem_resp", {31'b0, imem_resp}, 32'd1);
        chk("t1_c8_imem_rdata", imem_rdata, 32'h0000_00A5);
        chk("t1_c8_perf_istall", perf_istall, PERF_ON ? 32'd7 : 32'd0);
        chk("t1_c8_perf_dstall", perf_dstall, 32'd0);
        tick();
        chk("t1_c9_resp_low", {31'b0, imem_resp}, 32'd0);
        chk("t1_c9_idle", {31'b0, mem_read}, 32'd0);

        // Simultaneous requests: dmem first, then imem on the first IDLE cycle.
        do_reset();
        imem_read    = 1'b1;
        imem_address = 32'h0000_0100;
        dmem_read    = 1'b1;
        dmem_address = 32'h0000_2004;
        tick();
        chk("t2_c1_dgrant_addr", mem_address, 32'h0000_2004);
        chk("t2_c1_mem_read", {31'b0, mem_read}, 32'd1);
        mem_resp  = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        chk("t2_c2_dmem_resp", {31'b0, dmem_resp}, 32'd1);
        chk("t2_c2_dmem_rdata", dmem_rdata, 32'hCAFE_0001);
        chk("t2_c2_imem_resp", {31'b0, imem_resp}, 32'd0);
        tick();
        dmem_read = 1'b0;
        chk("t2_c3_dead_cycle", {31'b0, mem_read}, 32'd0);
        tick();
        chk("t2_c4_igrant", {31'b0, mem_read}, 32'd1);
        chk("t2_c4_igrant_addr", mem_address, 32'h0000_0100);
        mem_resp  = 1'b1;
        mem_rdata = 32'h1111_2222;
        tick();
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        imem_read = 1'b0;
        chk("t2_c5_imem_resp", {31'b0, imem_resp}, 32'd1);
        chk("t2_c5_imem_rdata", imem_rdata, 32'h1111_2222);
        chk("t2_c5_dmem_rdata_hold", dmem_rdata, 32'hCAFE_0001);

        // Unaligned store: address aligned, byte enables passed through.
        do_reset();
        dmem_write   = 1'b1;
        dmem_address = 32'h0000_1003;
        dmem_wdata   = 32'hDEAD_BEEF;
        dmem_mbe     = 4'b1000;
        tick();
        chk("t3_c1_mem_write", {31'b0, mem_write}, 32'd1);
        chk("t3_c1_mem_read", {31'b0, mem_read}, 32'd0);
        chk("t3_c1_addr", mem_address, 32'h0000_1000);
        chk("t3_c1_mbe", {28'b0, mem_mbe}, 32'h8);
        chk("t3_c1_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick();
        chk("t3_c2_mem_write_held", {31'b0, mem_write}, 32'd1);
        mem_resp = 1'b1;
        tick();
        mem_resp   = 1'b0;
        dmem_write = 1'b0;
        chk("t3_c3_mem_write_drop", {31'b0, mem_write}, 32'd0);
        chk("t3_c3_dmem_resp", {31'b0, dmem_resp}, 32'd1);
        tick();
        chk("t3_c4_dmem_resp_once", {31'b0, dmem_resp}, 32'd0);
        chk("t3_c4_perf_dstall", perf_dstall, PERF_ON ? 32'd3 : 32'd0);

        // Starvation guard: four dmem grants, one forced imem grant, then dmem again.
        do_reset();
        imem_read    = 1'b1;
        imem_address = 32'h0000_0500;
        dmem_read    = 1'b1;
        dmem_address = 32'h0000_3000;
        for (int k = 0; k < 6; k++) begin
            serve(32'h5000_0000 + 32'(k), got_addr, got_wr);
            chk($sformatf("t4_grant%0d_addr", k), got_addr,
                exp_d[k] ? 32'h0000_3000 : 32'h0000_0500);
            chk($sformatf("t4_grant%0d_dresp", k), {31'b0, dmem_resp}, {31'b0, exp_d[k]});
            chk($sformatf("t4_grant%0d_iresp", k), {31'b0, imem_resp}, {31'b0, !exp_d[k]});
        end
        chk("t4_imem_rdata", imem_rdata, 32'h5000_0004);
        chk("t4_starve_after", 32'(dut.starve_cnt), 32'd1);

        // Asynchronous reset in the middle of a store.
        do_reset();
        imem_read    = 1'b1;
        imem_address = 32'h0000_0600;
        dmem_write   = 1'b1;
        dmem_address = 32'h0000_4000;
        dmem_wdata   = 32'h0000_0001;
        dmem_mbe     = 4'hF;
        serve(32'h0, got_addr, got_wr);
        chk("t5_first_addr", got_addr, 32'h0000_4000);
        chk("t5_first_is_write", {31'b0, got_wr}, 32'd1);
        tick();
        tick();
        chk("t5_dbusy_write", {31'b0, mem_write}, 32'd1);
        chk("t5_starve_before", 32'(dut.starve_cnt), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_mem_write", {31'b0, mem_write}, 32'd0);
        chk("t5_async_dmem_resp", {31'b0, dmem_resp}, 32'd0);
        chk("t5_async_starve", 32'(dut.starve_cnt), 32'd0);
        chk("t5_async_addr", mem_address, 32'h0);
        dmem_write = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        serve(32'h0000_0077, got_addr, got_wr);
        chk("t5_fetch_addr", got_addr, 32'h0000_0600);
        chk("t5_fetch_is_read", {31'b0, got_wr}, 32'd0);
        chk("t5_fetch_resp", {31'b0, imem_resp}, 32'd1);
        chk("t5_fetch_rdata", imem_rdata, 32'h0000_0077);
        imem_read = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_req_responder.md
Name: mem_req_responder

Overview:
- Memory-side responder for the CPU pipeline's instruction and data ports. It accepts the level-held imem_read and dmem_read/dmem_write requests and returns one-cycle imem_resp/dmem_resp pulses.
- It arbitrates both CPU ports onto one shared single-outstanding backing-memory port.
- Placement: between the CPU top (pipeline stage controller) and the cache/physical-memory adapter.

Parameters:
- STARVE_LIMIT, 4: consecutive dmem grants allowed while imem waits; imem is then forced.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- imem_read  in  1  fetch request, held until imem_resp
- imem_address  in  32  fetch byte address
- imem_rdata  out  32  fetch data, valid with imem_resp
- imem_resp  out  1  one-cycle completion pulse
- dmem_read  in  1  load request, held until dmem_resp
- dmem_write  in  1  store request, held until dmem_resp
- dmem_address  in  32  data byte address
- dmem_wdata  in  32  store data
- dmem_mbe  in  4  store byte enables
- dmem_rdata  out  32  load data, valid with dmem_resp
- dmem_resp  out  1  one-cycle completion pulse
- mem_read  out  1  backing read, held until mem_resp
- mem_write  out  1  backing write, held until mem_resp
- mem_address  out  32  word-aligned address ([1:0]=0)
- mem_wdata  out  32  backing write data
- mem_mbe  out  4  backing byte enables (4'hF on reads)
- mem_rdata  in  32  backing read data, valid with mem_resp
- mem_resp  in  1  backing completion pulse
- perf_istall  out  CNT_W  cycles with imem_read high and imem_resp low
- perf_dstall  out  CNT_W  cycles with (dmem_read|dmem_write) high and dmem_resp low

Behaviour:
- Reset (rst=0, async): state IDLE; all mem_* outputs, imem_resp, dmem_resp, rdata outputs, starve count and perf counters = 0.
- All outputs are registered.
- FSM states: IDLE, IBUSY, DBUSY, RESP.
- IDLE, arbitration on the current cycle's requests:
  - dmem request present and (imem_read=0 or starve_cnt<STARVE_LIMIT): latch dmem address/wdata/mbe/op, go to DBUSY.
  - Otherwise, imem_read present: latch imem request, go to IBUSY.
  - No request: stay in IDLE.
- Starve count:
  - Increments on each dmem grant taken while imem_read=1.
  - Clears on any imem grant, or on a dmem grant while imem_read=0.
  - Saturates at STARVE_LIMIT.
- IBUSY/DBUSY:
  - mem_read/mem_write are high from the first cycle in the state until the cycle mem_resp=1.
  - On mem_resp=1: drop mem_*, capture mem_rdata into the granted port's rdata register, assert that port's resp for exactly the next cycle, go to RESP.
- Latency: request seen in IDLE at cycle t → mem_* high at t+1. mem_resp at cycle k → CPU resp and rdata at k+1.
- RESP:
  - Lasts one cycle; resp is high during it.
  - Requests are ignored in RESP because the CPU still holds the completed request this cycle.
  - Next state is always IDLE, so there is one dead cycle before the next grant.
- Request withdrawn before grant: nothing is issued. After a grant, the transaction always completes; a mid-transaction drop of the CPU request does not abort the backing access.
- dmem_read and dmem_write both high: write wins; a simulation assertion fires.
- mem_resp while IDLE or RESP: ignored; a simulation assertion fires.
- Never assert imem_resp and dmem_resp in the same cycle.
- Reset mid-transaction: immediate abandon, all outputs 0. The backing memory is reset by the same rst.
- imem_rdata/dmem_rdata hold their last value outside resp cycles.

Optional Feature:
- Macro MEM_RESP_PERF_EN.
- Defined: perf_istall and perf_dstall count as described, each saturating at all-ones, cleared only by reset.
- Undefined: both ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Package mem_resp_pkg: state enum (IDLE, IBUSY, DBUSY, RESP), grant enum (GNT_I, GNT_D), default STARVE_LIMIT constant.
- One sub-module, mem_starve_ctr: a saturating up-counter with inc, clr and at_limit, instantiated once for the starve count.
- The perf counters reuse the same counter.

Test Plan:
- imem_read=1 @0x0000_0040, mem_resp 3 cycles after mem_read rises, mem_rdata=0x0000_0013 → mem_read high cycles 1–4, imem_resp=1 with imem_rdata=0x13 at cycle 5 only, next grant no earlier than cycle 7.
- imem_read and dmem_read both high in IDLE → dmem granted first. After dmem_resp, imem is granted on the first IDLE cycle.
- dmem_write @0x1003, wdata 0xDEADBEEF, mbe 4'b1000 → mem_address 0x1000, mem_mbe 4'b1000, mem_write held to mem_resp, then a single dmem_resp pulse.
- STARVE_LIMIT=4, dmem requests back-to-back with imem_read held → exactly 4 dmem grants, then an imem grant, then dmem resumes.
- rst low mid-DBUSY → mem_write, dmem_resp and the starve count go to 0 asynchronously. After release, a fresh imem request is served normally.
- MEM_RESP_PERF_EN defined, imem waits 6 cycles → perf_istall=6. Undefined → perf_istall=0.
